// File: rtl/spu_pkg.sv
// rtl/spu_pkg.sv - shared types and opcodes for the quadword permute pipe
package spu_pkg;

  typedef logic [0:127] quad_t;

  typedef enum logic [2:0] {
    FMT_RR  = 3'd0,
    FMT_RI7 = 3'd1
  } fmt_e;

  localparam logic [0:10] OP_SHLQBI  = 11'b00111011011;
  localparam logic [0:10] OP_SHLQBII = 11'b00111111011;
  localparam logic [0:10] OP_SHLQBY  = 11'b00111011111;
  localparam logic [0:10] OP_SHLQBYI = 11'b00111111111;
  localparam logic [0:10] OP_ROTQBI  = 11'b00111011000;
  localparam logic [0:10] OP_ROTQBII = 11'b00111111000;
  localparam logic [0:10] OP_ROTQBY  = 11'b00111011100;
  localparam logic [0:10] OP_ROTQBYI = 11'b00111111100;

endpackage

// File: rtl/permute_shift_core.sv
// rtl/permute_shift_core.sv - combinational quadword shift/rotate datapath
module permute_shift_core
  import spu_pkg::*;
#(
  parameter int OP_W = 11
) (
  input  logic [0:OP_W-1] op_i,
  input  logic [2:0]      format_i,
  input  quad_t           ra_i,
  input  quad_t           rb_i,
  input  logic [0:17]     imm_i,
  output quad_t           result_o,
  output logic            legal_o
);

  logic [2:0] bit_cnt;
  logic [4:0] byte_cnt;
  logic [7:0] bit_sh;
  logic [7:0] byte_sh;
  logic [7:0] rot_sh;
  quad_t      res;
  logic       known;

  always_comb begin
    bit_cnt  = (format_i == FMT_RI7) ? imm_i[15:17] : rb_i[29:31];
    byte_cnt = (format_i == FMT_RI7) ? imm_i[13:17] : rb_i[27:31];
    bit_sh   = {5'd0, bit_cnt};
    // Byte shifts of 16..31 give an amount >= 128, which zero-fills naturally.
    byte_sh  = {byte_cnt, 3'b000};
    rot_sh   = {1'b0, byte_cnt[3:0], 3'b000};
    res      = '0;
    known    = 1'b1;
    case (op_i)
      OP_SHLQBI, OP_SHLQBII: res = ra_i << bit_sh;
      OP_SHLQBY, OP_SHLQBYI: res = ra_i << byte_sh;
      OP_ROTQBI, OP_ROTQBII: res = (ra_i << bit_sh) | (ra_i >> (8'd128 - bit_sh));
      OP_ROTQBY, OP_ROTQBYI: res = (ra_i << rot_sh) | (ra_i >> (8'd128 - rot_sh));
      default:               known = 1'b0;
    endcase
    legal_o  = known && ((format_i == FMT_RR) || (format_i == FMT_RI7));
    result_o = legal_o ? res : '0;
  end

endmodule

// File: rtl/permute_pipe.sv
// rtl/permute_pipe.sv - odd-pipe permute unit: shift/rotate with stall, flush and forwarding taps
module permute_pipe
  import spu_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int ADDR_W = 7,
  parameter int OP_W   = 11
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [0:OP_W-1]            op,
  input  logic [2:0]                 format,
  input  logic [ADDR_W-1:0]          rt_addr,
  input  logic [0:127]               ra,
  input  logic [0:127]               rb,
  input  logic [0:17]                imm,
  input  logic                       reg_write,
  output logic [0:127]               rt_wb,
  output logic [ADDR_W-1:0]          rt_addr_wb,
  output logic                       reg_write_wb,
  output logic [STAGES*128-1:0]      fwd_rt,
  output logic [STAGES*ADDR_W-1:0]   fwd_addr,
  output logic [STAGES-1:0]          fwd_valid
);

  quad_t             core_result;
  logic              core_legal;

  quad_t             data_q  [STAGES];
  quad_t             data_d  [STAGES];
  logic [ADDR_W-1:0] addr_q  [STAGES];
  logic [ADDR_W-1:0] addr_d  [STAGES];
  logic              valid_q [STAGES];
  logic              valid_d [STAGES];

  permute_shift_core #(.OP_W(OP_W)) u_core (
    .op_i     (op),
    .format_i (format),
    .ra_i     (ra),
    .rb_i     (rb),
    .imm_i    (imm),
    .result_o (core_result),
    .legal_o  (core_legal)
  );

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign data_d[k]  = core_result;
      assign addr_d[k]  = rt_addr;
      assign valid_d[k] = reg_write & core_legal;
    end else begin : g_body
      assign data_d[k]  = data_q[k-1];
      assign addr_d[k]  = addr_q[k-1];
      assign valid_d[k] = valid_q[k-1];
    end

    // Flush overrides stall on the valid bit only; data simply holds or shifts.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        data_q[k]  <= '0;
        addr_q[k]  <= '0;
        valid_q[k] <= 1'b0;
      end else begin
        if (!stall) begin
          data_q[k] <= data_d[k];
          addr_q[k] <= addr_d[k];
        end
        valid_q[k] <= ~flush & (stall ? valid_q[k] : valid_d[k]);
      end
    end

    assign fwd_rt[k*128 +: 128]       = data_q[k];
    assign fwd_addr[k*ADDR_W +: ADDR_W] = addr_q[k];
    assign fwd_valid[k]               = valid_q[k];
  end

  assign rt_wb        = data_q[STAGES-1];
  assign rt_addr_wb   = addr_q[STAGES-1];
  assign reg_write_wb = valid_q[STAGES-1];

endmodule

// File: tb/tb_permute_pipe.sv
// tb/tb_permute_pipe.sv - scoreboard bench for permute_pipe at depths 4, 1 and 8
module tb_permute_pipe;
  import spu_pkg::*;

  localparam int NI = 3;

  function automatic int stg(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 8;
  endfunction

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [0:10] op = '0;
  logic [2:0]  format = '0;
  logic [6:0]  rt_addr = '0;
  logic [0:127] ra = '0;
  logic [0:127] rb = '0;
  logic [0:17] imm = '0;
  logic        reg_write = 1'b0;

  always #5 clk = ~clk;

  logic [0:127] wb4, wb1, wb8;
  logic [6:0]   wa4, wa1, wa8;
  logic         we4, we1, we8;
  logic [4*128-1:0] fr4;
  logic [127:0]     fr1;
  logic [8*128-1:0] fr8;
  logic [27:0]  fa4;
  logic [6:0]   fa1;
  logic [55:0]  fa8;
  logic [3:0]   fv4;
  logic [0:0]   fv1;
  logic [7:0]   fv8;

  permute_pipe #(.STAGES(4)) dut4 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .op(op), .format(format),
    .rt_addr(rt_addr), .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write),
    .rt_wb(wb4), .rt_addr_wb(wa4), .reg_write_wb(we4),
    .fwd_rt(fr4), .fwd_addr(fa4), .fwd_valid(fv4));

  permute_pipe #(.STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .op(op), .format(format),
    .rt_addr(rt_addr), .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write),
    .rt_wb(wb1), .rt_addr_wb(wa1), .reg_write_wb(we1),
    .fwd_rt(fr1), .fwd_addr(fa1), .fwd_valid(fv1));

  permute_pipe #(.STAGES(8)) dut8 (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .op(op), .format(format),
    .rt_addr(rt_addr), .ra(ra), .rb(rb), .imm(imm), .reg_write(reg_write),
    .rt_wb(wb8), .rt_addr_wb(wa8), .reg_write_wb(we8),
    .fwd_rt(fr8), .fwd_addr(fa8), .fwd_valid(fv8));

  logic [0:127]     u_wb [NI];
  logic [6:0]       u_wa [NI];
  logic             u_we [NI];
  logic [8*128-1:0] u_fr [NI];
  logic [55:0]      u_fa [NI];
  logic [7:0]       u_fv [NI];

  always_comb begin
    u_wb[0] = wb4;  u_wa[0] = wa4;  u_we[0] = we4;
    u_wb[1] = wb1;  u_wa[1] = wa1;  u_we[1] = we1;
    u_wb[2] = wb8;  u_wa[2] = wa8;  u_we[2] = we8;
    u_fr[0] = 1024'(fr4); u_fa[0] = 56'(fa4); u_fv[0] = 8'(fv4);
    u_fr[1] = 1024'(fr1); u_fa[1] = 56'(fa1); u_fv[1] = 8'(fv1);
    u_fr[2] = fr8;        u_fa[2] = fa8;       u_fv[2] = fv8;
  end

  typedef struct {
    logic [0:127] res;
    logic [6:0]   addr;
    logic         we;
    int           iss;
  } ent_t;

  ent_t sb [NI][$];
  int   adv = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic use_exp = 1'b0;
  logic [0:127] exp_val = '0;

  // Reference: big-endian bit/byte index arithmetic, independent of shift operators.
  function automatic logic [0:127] ref_model(input logic [0:10] o, input logic [2:0] f,
                                             input logic [0:127] a, input logic [0:127] b,
                                             input logic [0:17] im, output logic lg);
    logic [0:127] r;
    logic [31:0]  w0;
    int bitc, bytec;
    w0    = b[0:31];
    bitc  = (f == 3'd1) ? int'(im) % 8  : int'(w0 % 32'd8);
    bytec = (f == 3'd1) ? int'(im) % 32 : int'(w0 % 32'd32);
    r  = '0;
    lg = 1'b1;
    case (o)
      OP_SHLQBI, OP_SHLQBII:
        for (int i = 0; i < 128; i++) if (i + bitc < 128) r[i] = a[i + bitc];
      OP_SHLQBY, OP_SHLQBYI:
        for (int j = 0; j < 16; j++) if (j + bytec < 16) r[j*8 +: 8] = a[(j + bytec)*8 +: 8];
      OP_ROTQBI, OP_ROTQBII:
        for (int i = 0; i < 128; i++) r[i] = a[(i + bitc) % 128];
      OP_ROTQBY, OP_ROTQBYI:
        for (int j = 0; j < 16; j++) r[j*8 +: 8] = a[((j + bytec) % 16)*8 +: 8];
      default: lg = 1'b0;
    endcase
    if (f > 3'd1) lg = 1'b0;
    if (!lg) r = '0;
    return r;
  endfunction

  function automatic logic [0:10] pick_op(input int k);
    case (k)
      0: return OP_SHLQBI;  1: return OP_SHLQBII;
      2: return OP_SHLQBY;  3: return OP_SHLQBYI;
      4: return OP_ROTQBI;  5: return OP_ROTQBII;
      6: return OP_ROTQBY;  7: return OP_ROTQBYI;
      default: return 11'd0;
    endcase
  endfunction

  // One clock edge; the model sees exactly what the DUTs sampled.
  task automatic tick();
    ent_t e;
    logic lg;
    @(posedge clk);
    if (!reset) begin
      for (int i = 0; i < NI; i++) sb[i].delete();
    end else begin
      if (flush) for (int i = 0; i < NI; i++) sb[i].delete();
      if (!stall) begin
        adv++;
        if (!flush) begin
          e.res  = ref_model(op, format, ra, rb, imm, lg);
          if (use_exp) e.res = exp_val;
          e.we   = reg_write & lg;
          e.addr = rt_addr;
          e.iss  = adv;
          for (int i = 0; i < NI; i++) sb[i].push_back(e);
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic [0:10] o, input logic [2:0] f, input logic [0:127] a,
                       input logic [0:127] b, input logic [0:17] im, input logic we);
    op = o; format = f; ra = a; rb = b; imm = im; reg_write = we;
    rt_addr = 7'($urandom);
    tick();
  endtask

  task automatic drive_rand(input logic we);
    int k;
    logic [0:10] o;
    k = int'($urandom_range(0, 7));
    o = pick_op(k);
    drive(o, {2'b00, o[5]}, {$urandom, $urandom, $urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom}, 18'($urandom), we);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive(11'd0, 3'd0, '0, '0, '0, 1'b0);
  endtask

  task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [STAGES=%0d] t=%0t got %h expected %h", nm, stg(inst), $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int s, p;
    logic [7:0] efv;
    for (int i = 0; i < NI; i++) begin
      s = stg(i);
      if (!reset) begin
        chk("rst_we", i, 128'(u_we[i]), '0);
        chk("rst_rt", i, u_wb[i], '0);
        chk("rst_addr", i, 128'(u_wa[i]), '0);
        chk("rst_fwd_valid", i, 128'(u_fv[i]), '0);
        chk("rst_fwd_or", i, 128'(|{u_fr[i], u_fa[i]}), '0);
      end else begin
        while (sb[i].size() > 0 && adv - sb[i][0].iss >= s) void'(sb[i].pop_front());
        efv = '0;
        for (int j = 0; j < sb[i].size(); j++) begin
          p = adv - sb[i][j].iss;
          efv[p] = sb[i][j].we;
          chk("fwd_rt", i, u_fr[i][p*128 +: 128], sb[i][j].res);
          chk("fwd_addr", i, 128'(u_fa[i][p*7 +: 7]), 128'(sb[i][j].addr));
          if (p == s - 1) begin
            chk("rt_wb", i, u_wb[i], sb[i][j].res);
            chk("rt_addr_wb", i, 128'(u_wa[i]), 128'(sb[i][j].addr));
          end
        end
        chk("fwd_valid", i, 128'(u_fv[i]), 128'(efv));
        chk("reg_write_wb", i, 128'(u_we[i]), 128'(efv[s-1]));
      end
    end
  end

  initial begin
    // reset held while a stream of writing ops is presented
    for (int c = 0; c < 4; c++) drive_rand(1'b1);
    reset = 1'b1;
    drive_rand(1'b1);
    idle(8);

    use_exp = 1'b1;
    exp_val = {{31{4'hF}}, 4'hC};
    drive(OP_SHLQBI, 3'd0, {{31{4'hF}}, 4'hE}, {32'd1, 96'd0}, '0, 1'b1);
    exp_val = {{31{4'h0}}, 4'h3};
    drive(OP_ROTQBI, 3'd0, {4'h8, {30{4'h0}}, 4'h1}, {32'd1, 96'd0}, '0, 1'b1);
    exp_val = '0;
    drive(OP_SHLQBY, 3'd0, 128'h00101131337377F7FF000000000000FF, {32'd16, 96'd0}, '0, 1'b1);
    exp_val = 128'h101131337377F7FF000000000000FF00;
    drive(OP_ROTQBYI, 3'd1, 128'h00101131337377F7FF000000000000FF, '0, 18'd1, 1'b1);
    use_exp = 1'b0;
    drive(11'd0, 3'd0, {4{32'hDEADBEEF}}, '0, '0, 1'b1);
    idle(9);

    // stall two cycles with three ops in flight
    for (int c = 0; c < 3; c++) drive_rand(1'b1);
    stall = 1'b1;
    drive_rand(1'b1);
    drive_rand(1'b1);
    stall = 1'b0;
    idle(9);

    // flush together with stall right after three issues
    for (int c = 0; c < 3; c++) drive_rand(1'b1);
    stall = 1'b1;
    flush = 1'b1;
    drive_rand(1'b1);
    stall = 1'b0;
    flush = 1'b0;
    idle(9);

    for (int c = 0; c < 400; c++) begin
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 9) == 0)
        drive(11'($urandom), 3'($urandom), {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 18'($urandom), 1'($urandom));
      else if ($urandom_range(0, 19) == 0) begin
        op = pick_op(int'($urandom_range(0, 7)));
        drive(op, 3'($urandom_range(2, 7)), {4{$urandom}}, {4{$urandom}}, 18'($urandom), 1'b1);
      end else
        drive_rand($urandom_range(0, 4) != 0);
    end
    stall = 1'b0;
    flush = 1'b0;

    // asynchronous reset with work in flight
    for (int c = 0; c < 3; c++) drive_rand(1'b1);
    reset = 1'b0;
    drive_rand(1'b1);
    drive_rand(1'b1);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) drive_rand(1'b1);
    idle(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
